// File: rtl/mempool_pkg.sv
// rtl/mempool_pkg.sv - shared types, register offsets and helpers for the MemPool DMA frontend
package mempool_pkg;

    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned CfgAddrWidth = 5;
    localparam int unsigned CfgDataWidth = 32;

    // Burst request handed to the DMA backend
    typedef struct packed {
        logic [AddrWidth-1:0] src;
        logic [AddrWidth-1:0] dst;
        logic [AddrWidth-1:0] num_bytes;
    } dma_req_t;

    // Registered status coming back from the cluster DMA
    typedef struct packed {
        logic backend_idle;
        logic trans_complete;
    } dma_meta_t;

    // Config register byte offsets
    localparam logic [CfgAddrWidth-1:0] RegSrc      = 5'h00;
    localparam logic [CfgAddrWidth-1:0] RegDst      = 5'h04;
    localparam logic [CfgAddrWidth-1:0] RegNumBytes = 5'h08;
    localparam logic [CfgAddrWidth-1:0] RegStatus   = 5'h0C;
    localparam logic [CfgAddrWidth-1:0] RegNextId   = 5'h10;
    localparam logic [CfgAddrWidth-1:0] RegDoneId   = 5'h14;

    typedef enum logic {
        DmaFeIdle  = 1'b0,
        DmaFeIssue = 1'b1
    } dma_fe_state_e;

    // A read of NEXT_ID is the only access with a side effect (it launches a transfer)
    function automatic logic is_next_id_read(
        input logic                    valid,
        input logic                    write,
        input logic [CfgAddrWidth-1:0] addr
    );
        return valid && !write && (addr == RegNextId);
    endfunction

endpackage

// File: rtl/mempool_dma_frontend_regs.sv
// rtl/mempool_dma_frontend_regs.sv - config register file, access handshake and read response path
module mempool_dma_frontend_regs
    import mempool_pkg::*;
#(
    parameter int unsigned AddrWidth = mempool_pkg::AddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic                 i_cfg_write,
    input  logic [4:0]           i_cfg_addr,
    input  logic [31:0]          i_cfg_wdata,
    output logic [31:0]          o_cfg_rdata,
    output logic                 o_cfg_rvalid,
    input  logic                 i_launch_block,
    input  logic                 i_busy,
    input  logic [31:0]          i_next_id,
    input  logic [31:0]          i_done_id,
    output logic                 o_launch,
    output logic [AddrWidth-1:0] o_src,
    output logic [AddrWidth-1:0] o_dst,
    output logic [AddrWidth-1:0] o_num_bytes
);

    logic [AddrWidth-1:0] r_src;
    logic [AddrWidth-1:0] r_dst;
    logic [AddrWidth-1:0] r_num_bytes;
    logic [31:0]          r_rdata;
    logic                 r_rvalid;

    logic                 w_next_id_rd;
    logic                 w_accept;
    logic [31:0]          w_rdata;

    // Only a launch can be held off; every other access completes in its request cycle
    assign w_next_id_rd = is_next_id_read(i_cfg_valid, i_cfg_write, i_cfg_addr);
    assign o_cfg_ready  = !(w_next_id_rd && i_launch_block);
    assign w_accept     = i_cfg_valid && o_cfg_ready;
    assign o_launch     = w_accept && w_next_id_rd;

    assign o_src        = r_src;
    assign o_dst        = r_dst;
    assign o_num_bytes  = r_num_bytes;
    assign o_cfg_rdata  = r_rdata;
    assign o_cfg_rvalid = r_rvalid;

    // Writable transfer descriptor; writes to read-only or unmapped offsets fall through
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_num_bytes <= '0;
        end else if (w_accept && i_cfg_write) begin
            case (i_cfg_addr)
                RegSrc:      r_src       <= i_cfg_wdata[AddrWidth-1:0];
                RegDst:      r_dst       <= i_cfg_wdata[AddrWidth-1:0];
                RegNumBytes: r_num_bytes <= i_cfg_wdata[AddrWidth-1:0];
                default:     ;
            endcase
        end
    end

    // Read mux; NEXT_ID returns the id being handed out by this very access
    always_comb begin
        w_rdata = '0;
        case (i_cfg_addr)
            RegSrc:      w_rdata = 32'(r_src);
            RegDst:      w_rdata = 32'(r_dst);
            RegNumBytes: w_rdata = 32'(r_num_bytes);
            RegStatus:   w_rdata = {31'd0, i_busy};
            RegNextId:   w_rdata = i_next_id;
            RegDoneId:   w_rdata = i_done_id;
            default:     w_rdata = '0;
        endcase
    end

    // One response strobe per accepted access, one cycle later; writes respond with zero data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_accept;
            if (w_accept) begin
                r_rdata <= i_cfg_write ? 32'd0 : w_rdata;
            end
        end
    end

endmodule

// File: rtl/mempool_dma_frontend.sv
// rtl/mempool_dma_frontend.sv - DMA launch frontend: issue FSM and id/outstanding counters (irq_o with MEMPOOL_DMA_FRONTEND_IRQ_EN)
module mempool_dma_frontend
    import mempool_pkg::*;
#(
    parameter int unsigned NumOutstanding = 16,
    parameter int unsigned AddrWidth      = mempool_pkg::AddrWidth
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic        cfg_write_i,
    input  logic [4:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic        cfg_rvalid_o,
    output dma_req_t    dma_req_o,
    output logic        dma_req_valid_o,
    input  logic        dma_req_ready_i,
    input  dma_meta_t   dma_meta_i
`ifdef MEMPOOL_DMA_FRONTEND_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    // One extra bit so the counter can hold NumOutstanding itself
    localparam int unsigned OutW = $clog2(NumOutstanding) + 1;

    dma_fe_state_e        r_state;
    dma_req_t             r_req;
    logic                 r_req_valid;
    logic [31:0]          r_next_id;
    logic [31:0]          r_done_id;
    logic [OutW-1:0]      r_outstanding;
    logic                 r_zero_pend;

    logic                 w_launch;
    logic                 w_launch_nz;
    logic                 w_launch_zero;
    logic                 w_complete;
    logic                 w_full;
    logic                 w_launch_block;
    logic                 w_busy;
    logic                 w_handshake;
    logic [AddrWidth-1:0] w_src;
    logic [AddrWidth-1:0] w_dst;
    logic [AddrWidth-1:0] w_num_bytes;

    mempool_dma_frontend_regs #(
        .AddrWidth (AddrWidth)
    ) u_regs (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_cfg_valid    (cfg_valid_i),
        .o_cfg_ready    (cfg_ready_o),
        .i_cfg_write    (cfg_write_i),
        .i_cfg_addr     (cfg_addr_i),
        .i_cfg_wdata    (cfg_wdata_i),
        .o_cfg_rdata    (cfg_rdata_o),
        .o_cfg_rvalid   (cfg_rvalid_o),
        .i_launch_block (w_launch_block),
        .i_busy         (w_busy),
        .i_next_id      (r_next_id),
        .i_done_id      (r_done_id),
        .o_launch       (w_launch),
        .o_src          (w_src),
        .o_dst          (w_dst),
        .o_num_bytes    (w_num_bytes)
    );

    // A completion with nothing outstanding is spurious and must not move any counter
    assign w_full         = (r_outstanding == OutW'(NumOutstanding));
    assign w_launch_block = (r_state == DmaFeIssue) || w_full;
    assign w_launch_zero  = w_launch && (w_num_bytes == '0);
    assign w_launch_nz    = w_launch && (w_num_bytes != '0);
    assign w_complete     = dma_meta_i.trans_complete && (r_outstanding != '0);
    assign w_handshake    = r_req_valid && dma_req_ready_i;
    assign w_busy         = (r_state == DmaFeIssue) || (r_outstanding != '0) || !dma_meta_i.backend_idle;

    assign dma_req_o       = r_req;
    assign dma_req_valid_o = r_req_valid;

    // Issue FSM: capture the descriptor on launch, hold it until the backend takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= DmaFeIdle;
            r_req       <= '0;
            r_req_valid <= 1'b0;
        end else begin
            case (r_state)
                DmaFeIdle: begin
                    if (w_launch_nz) begin
                        r_req.src       <= w_src;
                        r_req.dst       <= w_dst;
                        r_req.num_bytes <= w_num_bytes;
                        r_req_valid     <= 1'b1;
                        r_state         <= DmaFeIssue;
                    end
                end
                DmaFeIssue: begin
                    if (w_handshake) begin
                        r_req_valid <= 1'b0;
                        r_state     <= DmaFeIdle;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_state     <= DmaFeIdle;
                end
            endcase
        end
    end

    // Id counters and in-flight count; zero-length launches retire on the following cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_next_id     <= '0;
            r_done_id     <= '0;
            r_outstanding <= '0;
            r_zero_pend   <= 1'b0;
        end else begin
            if (w_launch) begin
                r_next_id <= r_next_id + 32'd1;
            end
            r_outstanding <= r_outstanding + OutW'(w_launch_nz) - OutW'(w_complete);
            r_zero_pend   <= w_launch_zero;
            r_done_id     <= r_done_id + 32'(w_complete) + 32'(r_zero_pend);
        end
    end

`ifdef MEMPOOL_DMA_FRONTEND_IRQ_EN
    logic r_irq;

    // Interrupt pulse aligned with every done_id advance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_complete || r_zero_pend;
        end
    end

    assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_mempool_dma_frontend.sv
// tb/tb_mempool_dma_frontend.sv - randomized self-checking bench with a transaction-level model
module tb_mempool_dma_frontend;
    import mempool_pkg::*;

    localparam int NOUT = 16;
    localparam logic [4:0] A_SRC = 5'h00, A_DST = 5'h04, A_NB = 5'h08;
    localparam logic [4:0] A_STATUS = 5'h0C, A_NEXT = 5'h10, A_DONE = 5'h14;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic        cfg_write_i = 1'b0;
    logic [4:0]  cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic [31:0] cfg_rdata_o;
    logic        cfg_rvalid_o;
    dma_req_t    dma_req_o;
    logic        dma_req_valid_o;
    logic        dma_req_ready_i = 1'b0;
    dma_meta_t   dma_meta_i = '{backend_idle: 1'b1, trans_complete: 1'b0};
`ifdef MEMPOOL_DMA_FRONTEND_IRQ_EN
    logic        irq_o;
`endif

    always #5 clk_i = ~clk_i;

    mempool_dma_frontend #(.NumOutstanding(NOUT)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_write_i     (cfg_write_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_wdata_i     (cfg_wdata_i),
        .cfg_rdata_o     (cfg_rdata_o),
        .cfg_rvalid_o    (cfg_rvalid_o),
        .dma_req_o       (dma_req_o),
        .dma_req_valid_o (dma_req_valid_o),
        .dma_req_ready_i (dma_req_ready_i),
        .dma_meta_i      (dma_meta_i)
`ifdef MEMPOOL_DMA_FRONTEND_IRQ_EN
        ,
        .irq_o           (irq_o)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_src, m_dst, m_nb, m_next_id, m_done_id;
    int          m_out;
    dma_req_t    req_q[$];
    logic        rsp_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_src = '0; m_dst = '0; m_nb = '0; m_next_id = '0; m_done_id = '0; m_out = 0;
        req_q.delete();
    endfunction

    function automatic void model_complete();
        if (m_out > 0) begin
            m_out--;
            m_done_id++;
        end
    endfunction

    function automatic logic [31:0] model_launch();
        logic [31:0] id;
        id = m_next_id;
        m_next_id++;
        if (m_nb == 0) m_done_id++;
        else begin
            m_out++;
            req_q.push_back('{src: m_src, dst: m_dst, num_bytes: m_nb});
        end
        return id;
    endfunction

    // Backend model: random ready; checks every accepted request against the launch order
    initial begin
        dma_req_t prev_req;
        logic prev_valid, prev_ready;
        dma_req_t exp;
        prev_valid = 0; prev_ready = 0; prev_req = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_valid = 0; prev_ready = 0; dma_req_ready_i = 0;
            end else begin
                if (prev_valid && prev_ready) begin
                    if (req_q.size() == 0) check_eq("req_unexpected", 32'(req_q.size()), 1);
                    else begin
                        exp = req_q.pop_front();
                        check_eq("req_src", prev_req.src, exp.src);
                        check_eq("req_dst", prev_req.dst, exp.dst);
                        check_eq("req_nb", prev_req.num_bytes, exp.num_bytes);
                    end
                end
                prev_valid = dma_req_valid_o;
                prev_req = dma_req_o;
                dma_req_ready_i = (rsp_en && dma_req_valid_o) ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_ready = dma_req_ready_i;
            end
        end
    end

    task automatic cfg_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int n;
        @(negedge clk_i);
        cfg_valid_i = 1; cfg_write_i = wr; cfg_addr_i = addr; cfg_wdata_i = wdata;
        #1;
        n = 0;
        while (!cfg_ready_o && n < 300) begin
            @(negedge clk_i); #1; n++;
        end
        if (n >= 300) begin
            check_eq("cfg_ready_timeout", cfg_ready_o, 1);
            cfg_valid_i = 0; rdata = '0;
            return;
        end
        @(negedge clk_i);
        cfg_valid_i = 0;
        check_eq("cfg_rvalid", cfg_rvalid_o, 1);
        rdata = cfg_rdata_o;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((req_q.size() != 0 || dma_req_valid_o) && n < 400) begin
            @(negedge clk_i); n++;
        end
        if (n >= 400) check_eq("idle_timeout", 32'(req_q.size()), 0);
    endtask

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] d);
        logic [31:0] dummy;
        cfg_xfer(1, addr, d, dummy);
        case (addr)
            A_SRC: m_src = d;
            A_DST: m_dst = d;
            A_NB:  m_nb = d;
            default: ;
        endcase
    endtask

    task automatic reg_read(input string tag, input logic [4:0] addr);
        logic [31:0] got, exp;
        if (addr == A_STATUS) wait_idle();
        case (addr)
            A_SRC:    exp = m_src;
            A_DST:    exp = m_dst;
            A_NB:     exp = m_nb;
            A_STATUS: exp = {31'd0, (m_out != 0) || !dma_meta_i.backend_idle};
            A_DONE:   exp = m_done_id;
            default:  exp = 32'd0;
        endcase
        cfg_xfer(0, addr, 32'd0, got);
        check_eq(tag, got, exp);
    endtask

    task automatic launch(input string tag);
        logic [31:0] got, exp;
        cfg_xfer(0, A_NEXT, 32'd0, got);
        exp = model_launch();
        check_eq(tag, got, exp);
    endtask

    task automatic pulse_complete();
        @(negedge clk_i); dma_meta_i.trans_complete = 1;
        @(negedge clk_i); dma_meta_i.trans_complete = 0;
        model_complete();
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 0; cfg_valid_i = 0; rsp_en = 0;
        dma_meta_i = '{backend_idle: 1'b1, trans_complete: 1'b0};
        repeat (2) @(negedge clk_i);
        model_reset();
        rst_ni = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_id;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_eq("rst_cfg_ready", cfg_ready_o, 1);
        check_eq("rst_rvalid", cfg_rvalid_o, 0);
        check_eq("rst_rdata", cfg_rdata_o, 0);
        check_eq("rst_req_valid", dma_req_valid_o, 0);
        check_eq("rst_req_src", dma_req_o.src, 0);
        check_eq("rst_req_nb", dma_req_o.num_bytes, 0);
        rst_ni = 1;
        reg_read("rst_src", A_SRC);
        reg_read("rst_status", A_STATUS);
        reg_read("rst_done", A_DONE);

        // basic launch, request held through backpressure
        reg_write(A_SRC, 32'h0000_1000);
        reg_write(A_DST, 32'h8000_0000);
        reg_write(A_NB, 32'h0000_0400);
        rsp_en = 0;
        launch("first_id");
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_valid", dma_req_valid_o, 1);
            check_eq("hold_src", dma_req_o.src, 32'h0000_1000);
            check_eq("hold_dst", dma_req_o.dst, 32'h8000_0000);
            check_eq("hold_nb", dma_req_o.num_bytes, 32'h0000_0400);
            @(negedge clk_i);
        end
        rsp_en = 1;
        wait_idle();

        // zero-length launch
        reg_write(A_NB, 32'd0);
        launch("zero_id");
        for (int i = 0; i < 3; i++) begin
            check_eq("zero_no_valid", dma_req_valid_o, 0);
            @(negedge clk_i);
        end
        reg_read("zero_done", A_DONE);

        // id wrap
        @(negedge clk_i);
        force dut.r_next_id = 32'hFFFF_FFFF;
        #1;
        release dut.r_next_id;
        m_next_id = 32'hFFFF_FFFF;
        launch("wrap_max");
        launch("wrap_zero");

        // outstanding limit
        apply_reset();
        rsp_en = 1;
        reg_write(A_SRC, 32'h0000_2000);
        reg_write(A_DST, 32'h0000_3000);
        reg_write(A_NB, 32'h0000_0100);
        for (int i = 0; i < NOUT; i++) launch("fill_id");
        wait_idle();
        fork
            launch("full_id");
            begin
                repeat (4) @(negedge clk_i);
                #2;
                check_eq("full_stall", cfg_ready_o, 0);
                pulse_complete();
            end
        join
        reg_read("full_done", A_DONE);

        // launch coincident with a completion
        apply_reset();
        rsp_en = 1;
        reg_write(A_NB, 32'h0000_0040);
        repeat (3) launch("coinc_fill");
        wait_idle();
        @(negedge clk_i);
        cfg_valid_i = 1; cfg_write_i = 0; cfg_addr_i = A_NEXT; dma_meta_i.trans_complete = 1;
        #1;
        check_eq("coinc_ready", cfg_ready_o, 1);
        @(negedge clk_i);
        cfg_valid_i = 0; dma_meta_i.trans_complete = 0;
        model_complete();
        exp_id = model_launch();
        check_eq("coinc_rvalid", cfg_rvalid_o, 1);
        check_eq("coinc_id", cfg_rdata_o, exp_id);
        reg_read("coinc_done", A_DONE);
        repeat (4) pulse_complete();
        reg_read("coinc_out3", A_DONE);
        reg_read("coinc_status", A_STATUS);

        // reset in the middle of an issue
        reg_write(A_NB, 32'h0000_0080);
        rsp_en = 0;
        launch("rst_launch");
        check_eq("rst_pre_valid", dma_req_valid_o, 1);
        #2 rst_ni = 0;
        #1 check_eq("rst_async_drop", dma_req_valid_o, 0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        reg_read("rst_status_after", A_STATUS);

        // randomized traffic against the model
        rsp_en = 1;
        for (int it = 0; it < 200; it++) begin
            int op;
            logic [4:0] a;
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                case ($urandom_range(0, 5))
                    0: a = A_SRC;
                    1: a = A_DST;
                    2: a = A_NB;
                    3: a = A_STATUS;
                    4: a = A_NEXT;
                    default: a = 5'h18;
                endcase
                if (a == A_NB) reg_write(a, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 4096)));
                else reg_write(a, $urandom);
            end else if (op <= 3) begin
                case ($urandom_range(0, 6))
                    0: a = A_SRC;
                    1: a = A_DST;
                    2: a = A_NB;
                    3: a = A_STATUS;
                    4: a = A_DONE;
                    5: a = 5'h1C;
                    default: a = 5'h02;
                endcase
                reg_read("rnd_read", a);
            end else if (op <= 6) begin
                if (m_out < NOUT) launch("rnd_id");
                else pulse_complete();
            end else if (op <= 8) begin
                pulse_complete();
            end else begin
                dma_meta_i.backend_idle = 1'($urandom_range(0, 1));
            end
        end
        dma_meta_i.backend_idle = 1;
        wait_idle();
        reg_read("end_done", A_DONE);
        reg_read("end_status", A_STATUS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mempool_dma_frontend.md
MEMPOOL_DMA_FRONTEND -- requirements
Module: mempool_dma_frontend

Interface
REQ-001 SHALL have parameter NumOutstanding, default 16, meaning the maximum number of issued but uncompleted transfers (power of two, 2..256).
REQ-002 SHALL have parameter AddrWidth, default mempool_pkg::AddrWidth, meaning the width of the address fields and NUM_BYTES.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk_i  in  1  clock.
REQ-005 Port rst_ni  in  1  asynchronous active-low reset.
REQ-006 Port cfg_valid_i  in  1  config access request.
REQ-007 Port cfg_ready_o  out  1  config access accepted.
REQ-008 Port cfg_write_i  in  1  1 = write, 0 = read.
REQ-009 Port cfg_addr_i  in  5  byte offset of the register.
REQ-010 Port cfg_wdata_i  in  32  write data.
REQ-011 Port cfg_rdata_o  out  32  read data, valid when cfg_rvalid_o is high.
REQ-012 Port cfg_rvalid_o  out  1  response strobe, one per accepted access (reads and writes).
REQ-013 Port dma_req_o  out  dma_req_t  burst request {src, dst, num_bytes}.
REQ-014 Port dma_req_valid_o / dma_req_ready_i  out/in  1/1  request handshake.
REQ-015 Port dma_meta_i  in  dma_meta_t  {backend_idle, trans_complete}, driven from the cluster's registered meta output.

Function
REQ-016 Register map: 0x00 SRC (RW), 0x04 DST (RW), 0x08 NUM_BYTES (RW), 0x0C STATUS (RO, bit0 = busy), 0x10 NEXT_ID (RO, a read launches a transfer), 0x14 DONE_ID (RO); unmapped reads SHALL return 0, unmapped writes SHALL be ignored.
REQ-017 FSM states: IDLE and ISSUE; a NEXT_ID read in IDLE SHALL latch SRC/DST/NUM_BYTES into dma_req_o and go to ISSUE; the FSM SHALL return to IDLE on the cycle dma_req_valid_o && dma_req_ready_i.
REQ-018 dma_req_valid_o SHALL be high exactly in ISSUE, and dma_req_o SHALL remain stable while it is high.
REQ-019 cfg_ready_o SHALL be low for any NEXT_ID read while the FSM is in ISSUE or while outstanding == NumOutstanding; all other accesses SHALL be accepted in the same cycle.
REQ-020 Read responses SHALL have a latency of 1 cycle (cfg_rvalid_o one cycle after acceptance).
REQ-021 A launch SHALL return the current 32-bit next_id and then increment next_id, wrapping 0xFFFF_FFFF to 0.
REQ-022 Each cycle with dma_meta_i.trans_complete high SHALL increment done_id and decrement outstanding by one.
REQ-023 A launch and a completion in the same cycle SHALL leave outstanding unchanged.
REQ-024 A trans_complete with outstanding == 0 SHALL be ignored: no underflow, done_id unchanged.
REQ-025 NUM_BYTES == 0 at launch SHALL return an ID, SHALL NOT enter ISSUE, and SHALL increment done_id one cycle later.
REQ-026 STATUS.busy SHALL equal (state == ISSUE) || outstanding != 0 || !dma_meta_i.backend_idle.

Reset
REQ-027 On reset: state IDLE; SRC/DST/NUM_BYTES, next_id, done_id and outstanding = 0; dma_req_valid_o = 0; dma_req_o = 0; cfg_rvalid_o = 0; cfg_rdata_o = 0; cfg_ready_o = 1; irq_o = 0.
REQ-028 Reset asserted during ISSUE SHALL drop dma_req_valid_o immediately (asynchronously); the pending request is discarded.

Configuration
REQ-029 With MEMPOOL_DMA_FRONTEND_IRQ_EN defined, the block SHALL provide output irq_o (1 bit), pulsed high for one cycle on each cycle in which done_id increments.
REQ-030 Without the macro, irq_o and its logic SHALL be absent.

Structure
REQ-031 dma_req_t, dma_meta_t and the register offset localparams SHALL live in mempool_pkg.
REQ-032 The config register file SHALL be a sub-module named mempool_dma_frontend_regs; the FSM and counters stay in the top.

Verification
REQ-033 Write SRC=0x1000, DST=0x8000_0000, NUM_BYTES=0x400, read NEXT_ID -> rdata 0; one request with those fields; valid is held through 3 cycles of ready=0.
REQ-034 Launch 16 transfers with no completion -> the 17th NEXT_ID read is stalled (cfg_ready_o=0) until one trans_complete pulse, then returns ID 16.
REQ-035 Launch coincident with trans_complete, outstanding=3 -> outstanding stays 3, done_id+1.
REQ-036 Launch with NUM_BYTES=0 -> returns ID, no dma_req_valid_o, DONE_ID read reads +1 after 1 cycle.
REQ-037 Force next_id=0xFFFF_FFFF, launch twice -> returns 0xFFFF_FFFF then 0.
REQ-038 Assert rst_ni mid-ISSUE -> dma_req_valid_o=0 at once; STATUS reads 0 after release.
